stop_watch_ctrl_mc: RTL and testbench



---
 rtl/stop_watch_pkg.sv | 30 +++
 rtl/sw_ch_fsm.sv | 96 +++++++++
 rtl/stop_watch_ctrl_mc.sv | 69 ++++++
 tb/tb_stop_watch_ctrl_mc.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// Shared state encoding and output decode for the multi-channel stopwatch controller.
package stop_watch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_CLEAR = 2'd3
    } sw_state_e;

    typedef struct packed {
        logic run;
        logic clear;
        logic lap_hold;
    } sw_out_t;

    function automatic sw_out_t sw_decode(input sw_state_e st);
        sw_out_t o;
        o = '0;
        case (st)
            ST_STOP:  o = '{run: 1'b0, clear: 1'b0, lap_hold: 1'b0};
            ST_RUN:   o = '{run: 1'b1, clear: 1'b0, lap_hold: 1'b0};
            ST_LAP:   o = '{run: 1'b1, clear: 1'b0, lap_hold: 1'b1};
            ST_CLEAR: o = '{run: 1'b0, clear: 1'b1, lap_hold: 1'b0};
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sw_ch_fsm.sv
// Single stopwatch channel: RUN/STOP/LAP/CLEAR Moore FSM with a self-terminating clear counter.
module sw_ch_fsm
    import stop_watch_pkg::*;
#(
    parameter int CLR_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    input  logic       i_all_start,
    input  logic       i_all_stop,
    output logic [1:0] o_state,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap_hold
);

    localparam int CNT_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    sw_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sw_out_t    dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Global strobes win over local ones; CLEAR keeps counting regardless.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STOP: begin
                if (i_all_start) begin
                    state_d = ST_RUN;
                end else if (i_all_stop) begin
                    state_d = ST_STOP;
                end else if (i_run_stop) begin
                    state_d = ST_RUN;
                end else if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CNT_W'(CLR_CYC - 1);
                end
            end
            ST_RUN: begin
                if (i_all_stop) begin
                    state_d = ST_STOP;
                end else if (i_all_start) begin
                    state_d = ST_RUN;
                end else if (i_run_stop) begin
                    state_d = ST_STOP;
                end else if (i_lap) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (i_all_stop) begin
                    state_d = ST_STOP;
                end else if (i_all_start) begin
                    state_d = ST_LAP;
                end else if (i_run_stop) begin
                    state_d = ST_STOP;
                end else if (i_lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_comb begin
        dec        = sw_decode(state_q);
        o_state    = state_q;
        o_run      = dec.run;
        o_clear    = dec.clear;
        o_lap_hold = dec.lap_hold;
    end

endmodule

// File: rtl/stop_watch_ctrl_mc.sv
// Multi-channel stopwatch controller: routes button pulses to the selected channel FSM.
// Optional global run/stop across all channels via STOP_WATCH_CTRL_MC_SYNC_ALL_EN.
module stop_watch_ctrl_mc
    import stop_watch_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CH_SEL_W = 1,
    parameter int CLR_CYC  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_SEL_W-1:0] i_ch_sel,
    input  logic                i_run_stop,
    input  logic                i_clear,
    input  logic                i_lap,
`ifdef STOP_WATCH_CTRL_MC_SYNC_ALL_EN
    input  logic                i_all_run_stop,
`endif
    output logic [N_CH-1:0]     o_run,
    output logic [N_CH-1:0]     o_clear,
    output logic [N_CH-1:0]     o_lap_hold,
    output logic [2*N_CH-1:0]   o_state
);

    logic            sel_valid;
    logic            all_pulse;
    logic            all_in_stop;
    logic            all_start;
    logic            all_stop;
    logic [N_CH-1:0] ch_is_stop;

`ifdef STOP_WATCH_CTRL_MC_SYNC_ALL_EN
    assign all_pulse = i_all_run_stop;
`else
    assign all_pulse = 1'b0;
`endif

    // Out-of-range selects silence every channel.
    assign sel_valid   = (32'(i_ch_sel) < N_CH);
    assign all_in_stop = &ch_is_stop;
    assign all_start   = all_pulse && all_in_stop;
    assign all_stop    = all_pulse && !all_in_stop;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic       hit;
        logic [1:0] st;

        assign hit           = sel_valid && (32'(i_ch_sel) == k) && !all_pulse;
        assign ch_is_stop[k] = (st == ST_STOP);
        assign o_state[2*k +: 2] = st;

        sw_ch_fsm #(
            .CLR_CYC (CLR_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_run_stop  (hit && i_run_stop),
            .i_lap       (hit && i_lap),
            .i_clear     (hit && i_clear),
            .i_all_start (all_start),
            .i_all_stop  (all_stop),
            .o_state     (st),
            .o_run       (o_run[k]),
            .o_clear     (o_clear[k]),
            .o_lap_hold  (o_lap_hold[k])
        );
    end

endmodule

// File: tb/tb_stop_watch_ctrl_mc.sv
// Directed bench for stop_watch_ctrl_mc with three channels and a 4-cycle clear.
// Global run/stop steps are included when STOP_WATCH_CTRL_MC_SYNC_ALL_EN is defined.
module tb_stop_watch_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] i_ch_sel = 2'd0;
    logic       i_run_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic       i_all_run_stop = 1'b0;
    logic [2:0] o_run;
    logic [2:0] o_clear;
    logic [2:0] o_lap_hold;
    logic [5:0] o_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stop_watch_ctrl_mc #(
        .N_CH     (3),
        .CH_SEL_W (2),
        .CLR_CYC  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ch_sel       (i_ch_sel),
        .i_run_stop     (i_run_stop),
        .i_clear        (i_clear),
        .i_lap          (i_lap),
`ifdef STOP_WATCH_CTRL_MC_SYNC_ALL_EN
        .i_all_run_stop (i_all_run_stop),
`endif
        .o_run          (o_run),
        .o_clear        (o_clear),
        .o_lap_hold     (o_lap_hold),
        .o_state        (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One pulse cycle: drive at negedge, sample 1 time unit after the posedge.
    task automatic cyc(input logic [1:0] sel, input logic rs, input logic lp,
                       input logic cl, input logic al);
        @(negedge clk);
        i_ch_sel       = sel;
        i_run_stop     = rs;
        i_lap          = lp;
        i_clear        = cl;
        i_all_run_stop = al;
        @(posedge clk);
        #1;
        i_run_stop     = 1'b0;
        i_lap          = 1'b0;
        i_clear        = 1'b0;
        i_all_run_stop = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_run",   32'(o_run),      32'h0);
        chk("rst_clear", 32'(o_clear),    32'h0);
        chk("rst_lap",   32'(o_lap_hold), 32'h0);
        chk("rst_state", 32'(o_state),    32'h0);
        @(negedge clk);
        rst = 1'b1;

`ifdef STOP_WATCH_CTRL_MC_SYNC_ALL_EN
        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("all_start_run",   32'(o_run),   32'h7);
        chk("all_start_state", 32'(o_state), 32'h15);
        cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("all_stop_state",  32'(o_state), 32'h00);
        cyc(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ch1_lap_state",   32'(o_state), 32'h08);
        cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("all_stop_lap_state", 32'(o_state),    32'h00);
        chk("all_stop_lap_hold",  32'(o_lap_hold), 32'h0);
`endif

        cyc(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ch1_run_orun",  32'(o_run),        32'h2);
        chk("ch1_run_st1",   32'(o_state[3:2]), 32'h1);
        chk("ch1_run_st0",   32'(o_state[1:0]), 32'h0);

        cyc(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_in_stop",   32'(o_state), 32'h04);

        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ch0_run_state", 32'(o_state), 32'h05);
        chk("ch0_run_orun",  32'(o_run),   32'h3);

        cyc(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap1_state",    32'(o_state),    32'h06);
        chk("lap1_hold",     32'(o_lap_hold), 32'h1);
        chk("lap1_run",      32'(o_run),      32'h3);

        cyc(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap2_state",    32'(o_state),    32'h05);
        chk("lap2_hold",     32'(o_lap_hold), 32'h0);

        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ch0_stop",      32'(o_state), 32'h04);

        cyc(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_c1",        32'(o_clear), 32'h1);
        chk("clr_c1_state",  32'(o_state), 32'h07);
        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_c2",        32'(o_clear), 32'h1);
        chk("clr_rs_ignored", 32'(o_run),  32'h2);
        cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_c3",        32'(o_clear), 32'h1);
        cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_c4",        32'(o_clear), 32'h1);
        cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_done",      32'(o_clear), 32'h0);
        chk("clr_done_state", 32'(o_state), 32'h04);

        cyc(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rs_over_clr",   32'(o_state), 32'h05);
        chk("rs_over_clr_c", 32'(o_clear), 32'h0);

        cyc(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lap_over_clr",  32'(o_state), 32'h06);

        cyc(2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sel_oob_state", 32'(o_state),    32'h06);
        chk("sel_oob_lap",   32'(o_lap_hold), 32'h1);

        cyc(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ch2_run_state", 32'(o_state), 32'h16);
        chk("ch2_run_orun",  32'(o_run),   32'h7);

        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lap_to_stop",      32'(o_state),    32'h14);
        chk("lap_to_stop_hold", 32'(o_lap_hold), 32'h0);

        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", 32'(o_state), 32'h16);

        #2;
        rst = 1'b0;
        #1;
        chk("arst_run",   32'(o_run),      32'h0);
        chk("arst_clear", 32'(o_clear),    32'h0);
        chk("arst_lap",   32'(o_lap_hold), 32'h0);
        chk("arst_state", 32'(o_state),    32'h0);
        @(negedge clk);
        rst = 1'b1;

        cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_run", 32'(o_state), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
